// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that shares one capture register among NREQ requesters,
// enforcing cycle-level setup/hold stability windows around each capture.
module reg_write_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [WIDTH-1:0]         q,
    output logic                     q_valid,
    output logic [$clog2(NREQ)-1:0]  q_src,
    output logic                     ack,
    output logic                     setup_viol,
    output logic                     hold_viol,
    output logic                     busy
);

    localparam int unsigned SRC_W   = $clog2(NREQ);
    localparam int unsigned CNT_MAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("reg_write_arbiter: NREQ must be in 2..8");
    end
    if (SETUP_CYC < 1 || HOLD_CYC < 1) begin : g_bad_cyc
        $error("reg_write_arbiter: SETUP_CYC and HOLD_CYC must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SRC_W-1:0]     w_q, w_d;
    logic [WIDTH-1:0]     snap_q, snap_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SRC_W-1:0]     ptr_q, ptr_d;

    logic [NREQ-1:0]      gnt_d;
    logic [WIDTH-1:0]     q_d;
    logic                 q_valid_d;
    logic [SRC_W-1:0]     q_src_d;
    logic                 ack_d;
    logic                 setup_viol_d;
    logic                 hold_viol_d;
    logic                 busy_d;

    logic [WIDTH-1:0]     wd [NREQ];
    logic                 found;
    logic [SRC_W-1:0]     pick;
    logic                 data_chg;
    logic                 setup_done;
    logic                 hold_done;

    for (genvar i = 0; i < NREQ; i++) begin : g_split
        assign wd[i] = wdata[i*WIDTH +: WIDTH];
    end

    // First asserted request at or above ptr, wrapping past NREQ-1.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(ptr_q) + i) % NREQ;
            if (!found && req[SRC_W'(idx)]) begin
                found = 1'b1;
                pick  = SRC_W'(idx);
            end
        end
    end

    assign data_chg   = (wd[w_q] != snap_q);
    assign setup_done = (cnt_q == CNT_W'(SETUP_CYC - 1));
    assign hold_done  = (cnt_q == CNT_W'(HOLD_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; abort has priority over a data change in SETUP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (found) state_d = SETUP;
            end
            SETUP: begin
                if (!req[w_q])              state_d = IDLE;
                else if (data_chg)          state_d = SETUP;
                else if (setup_done)        state_d = HOLD;
            end
            HOLD: begin
                if (hold_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the datapath and the registered outputs.
    always_comb begin
        w_d          = w_q;
        snap_d       = snap_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt;
        q_d          = q;
        q_valid_d    = 1'b0;
        q_src_d      = q_src;
        ack_d        = 1'b0;
        setup_viol_d = 1'b0;
        hold_viol_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    w_d    = pick;
                    gnt_d  = NREQ'(1) << pick;
                    snap_d = wd[pick];
                    cnt_d  = '0;
                end
            end
            SETUP: begin
                if (!req[w_q]) begin
                    gnt_d = '0;
                end else if (data_chg) begin
                    snap_d       = wd[w_q];
                    cnt_d        = '0;
                    setup_viol_d = 1'b1;
                end else if (setup_done) begin
                    q_d       = snap_q;
                    q_valid_d = 1'b1;
                    q_src_d   = w_q;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                hold_viol_d = data_chg;
                if (hold_done) begin
                    ack_d = 1'b1;
                    gnt_d = '0;
                    ptr_d = (w_q == SRC_W'(NREQ - 1)) ? '0 : w_q + SRC_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                gnt_d = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q        <= '0;
            snap_q     <= '0;
            cnt_q      <= '0;
            ptr_q      <= '0;
            gnt        <= '0;
            q          <= '0;
            q_valid    <= 1'b0;
            q_src      <= '0;
            ack        <= 1'b0;
            setup_viol <= 1'b0;
            hold_viol  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            w_q        <= w_d;
            snap_q     <= snap_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            gnt        <= gnt_d;
            q          <= q_d;
            q_valid    <= q_valid_d;
            q_src      <= q_src_d;
            ack        <= ack_d;
            setup_viol <= setup_viol_d;
            hold_viol  <= hold_viol_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter; captures are checked against a scoreboard
// of expected (data, source) pairs pushed when each transaction is launched.
module tb_reg_write_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req;
    logic [NREQ*WIDTH-1:0]  wdata;
    logic [NREQ-1:0]        gnt;
    logic [WIDTH-1:0]       q;
    logic                   q_valid;
    logic [1:0]             q_src;
    logic                   ack;
    logic                   setup_viol;
    logic                   hold_viol;
    logic                   busy;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [1:0]       src;
    } cap_t;

    cap_t sb[$];
    int   checks = 0;
    int   errors = 0;

    reg_write_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .SETUP_CYC(2), .HOLD_CYC(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata),
        .gnt(gnt), .q(q), .q_valid(q_valid), .q_src(q_src), .ack(ack),
        .setup_viol(setup_viol), .hold_viol(hold_viol), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [WIDTH-1:0] v);
        wdata[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input logic [1:0] s);
        cap_t c;
        c.data = d;
        c.src  = s;
        sb.push_back(c);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},   32'(gnt), 0);
        check({tag, "_q"},     32'(q), 0);
        check({tag, "_qv"},    32'(q_valid), 0);
        check({tag, "_qsrc"},  32'(q_src), 0);
        check({tag, "_ack"},   32'(ack), 0);
        check({tag, "_sv"},    32'(setup_viol), 0);
        check({tag, "_hv"},    32'(hold_viol), 0);
        check({tag, "_busy"},  32'(busy), 0);
    endtask

    // Every capture pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && q_valid) begin
            check("sb_nonempty", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                cap_t e;
                e = sb.pop_front();
                check("cap_q",   32'(q), 32'(e.data));
                check("cap_src", 32'(q_src), 32'(e.src));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Single requester, stable data.
        req = 4'b0001;
        set_data(0, 8'hA5);
        push(8'hA5, 2'd0);
        step(); check("t1_gnt", 32'(gnt), 32'h1); check("t1_busy", 32'(busy), 1);
        check("t1_qv_e0", 32'(q_valid), 0);
        step(); check("t1_qv_e1", 32'(q_valid), 0);
        step(); check("t1_qv_e2", 32'(q_valid), 1); check("t1_q", 32'(q), 32'hA5);
        check("t1_ack_e2", 32'(ack), 0);
        step(); check("t1_ack", 32'(ack), 1); check("t1_gnt_off", 32'(gnt), 0);
        check("t1_busy_off", 32'(busy), 0); check("t1_qv_e3", 32'(q_valid), 0);
        req = '0;
        step(); check("t1_ack_e4", 32'(ack), 0); check("t1_gnt_e4", 32'(gnt), 0);

        // Round robin from a fresh pointer.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_data(i, 8'(8'hC0 + i));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int idx;
            idx = k % 4;
            push(8'(8'hC0 + idx), 2'(idx));
            step(); check("rr_gnt", 32'(gnt), 32'(1) << idx);
            step();
            step(); check("rr_qv", 32'(q_valid), 1);
            step(); check("rr_ack", 32'(ack), 1);
        end
        req = '0;
        step(); check("rr_idle", 32'(gnt), 0);

        // Setup violation on requester 1 (pointer now 1).
        req = 4'b0010;
        set_data(1, 8'h11);
        push(8'h22, 2'd1);
        step(); check("sv_gnt", 32'(gnt), 32'h2); check("sv_e0", 32'(setup_viol), 0);
        set_data(1, 8'h22);
        step(); check("sv_pulse", 32'(setup_viol), 1); check("sv_qv_e1", 32'(q_valid), 0);
        step(); check("sv_clear", 32'(setup_viol), 0); check("sv_qv_e2", 32'(q_valid), 0);
        step(); check("sv_qv_e3", 32'(q_valid), 1); check("sv_q", 32'(q), 32'h22);
        step(); check("sv_ack", 32'(ack), 1);
        req = '0;

        // Hold violation on requester 2; req drop in HOLD is ignored.
        req = 4'b0100;
        set_data(2, 8'h33);
        push(8'h33, 2'd2);
        step(); check("hv_gnt", 32'(gnt), 32'h4);
        step();
        step(); check("hv_qv", 32'(q_valid), 1); check("hv_e2", 32'(hold_viol), 0);
        set_data(2, 8'h44);
        req = '0;
        step(); check("hv_pulse", 32'(hold_viol), 1); check("hv_ack", 32'(ack), 1);
        check("hv_q", 32'(q), 32'h33); check("hv_gnt_off", 32'(gnt), 0);
        step(); check("hv_clear", 32'(hold_viol), 0); check("hv_busy", 32'(busy), 0);

        // Abort on requester 3 with a simultaneous data change.
        req = 4'b1000;
        set_data(3, 8'h55);
        step(); check("ab_gnt", 32'(gnt), 32'h8);
        req = '0;
        set_data(3, 8'h56);
        step(); check("ab_gnt_off", 32'(gnt), 0); check("ab_busy", 32'(busy), 0);
        check("ab_sv", 32'(setup_viol), 0); check("ab_qv", 32'(q_valid), 0);
        check("ab_ack", 32'(ack), 0); check("ab_q", 32'(q), 32'h33);

        // Pointer still at 3, so 3 beats 0.
        req = 4'b1001;
        set_data(3, 8'h66);
        set_data(0, 8'h77);
        push(8'h66, 2'd3);
        step(); check("re_gnt", 32'(gnt), 32'h8);
        step();
        step(); check("re_qv", 32'(q_valid), 1);
        step(); check("re_ack", 32'(ack), 1);
        req = 4'b0001;
        push(8'h77, 2'd0);
        step(); check("r0_gnt", 32'(gnt), 32'h1);
        step();
        step(); check("r0_qv", 32'(q_valid), 1); check("r0_q", 32'(q), 32'h77);

        // Async reset in the middle of HOLD.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("areset");
        step();
        rst_n = 1'b1;
        set_data(0, 8'h88);
        push(8'h88, 2'd0);
        step(); check("pr_gnt", 32'(gnt), 32'h1); check("pr_busy", 32'(busy), 1);
        step();
        step(); check("pr_qv", 32'(q_valid), 1); check("pr_q", 32'(q), 32'h88);
        step(); check("pr_ack", 32'(ack), 1);
        req = '0;
        step();
        step();
        check("sb_drained", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin arbiter and write sequencer sharing one WIDTH-bit capture register among NREQ requesters. It grants one requester at a time and enforces a cycle-level data-stable window before capture (setup) and after capture (hold). Violations of either window are flagged as pulses. It sits in front of the shared flip-flop bank in gate-level timing exercises, as a synchronous cycle-level analogue of the setup/hold checks on the underlying flops.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, data width
- SETUP_CYC, 2, cycles granted data must be stable before capture (>=1)
- HOLD_CYC, 1, cycles granted data must stay stable after capture (>=1)

- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NREQ  per-requester write request, level
- wdata  in  NREQ*WIDTH  requester i data on wdata[i*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot grant, registered
- q  out  WIDTH  shared captured register
- q_valid  out  1  one-cycle pulse when q is written
- q_src  out  clog2(NREQ)  index of requester that last wrote q
- ack  out  1  one-cycle pulse at end of hold, transaction complete
- setup_viol  out  1  one-cycle pulse, granted data changed during setup
- hold_viol  out  1  one-cycle pulse, granted data changed during hold
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, SETUP, HOLD. Internals: winner index w, snapshot snap, counter cnt, round-robin pointer ptr.
- IDLE with any req: w = first asserted req searching from ptr upward, wrapping at NREQ-1 -> 0. Then gnt <= onehot(w), snap <= wdata[w], cnt <= 0, state <= SETUP. No req: stay IDLE.
- Each SETUP edge, evaluated in priority order:
  - req[w]==0: abort; gnt <= 0, state <= IDLE, q unchanged, no ack, ptr unchanged.
  - wdata[w] != snap: snap <= wdata[w], cnt <= 0, setup_viol pulse. The window restarts.
  - cnt == SETUP_CYC-1: q <= snap, q_valid pulse, q_src <= w, cnt <= 0, state <= HOLD.
  - otherwise cnt <= cnt+1.
- Each HOLD edge:
  - wdata[w] != snap raises a hold_viol pulse. q is never modified. Compare against snap, so a persistent change pulses on every hold cycle.
  - req[w] dropping during HOLD is ignored; the transaction completes.
  - cnt == HOLD_CYC-1: ack pulse, gnt <= 0, ptr <= (w+1) mod NREQ, state <= IDLE.
  - otherwise cnt <= cnt+1.
- Pointer advances only on ack; an aborted transaction leaves priority unchanged.
- Requests from non-granted requesters are ignored until the return to IDLE. There is no preemption.

## Timing
- Reset (asynchronous assert): gnt=0, q=0, q_valid=0, q_src=0, ack=0, setup_viol=0, hold_viol=0, busy=0, ptr=0, state=IDLE. Deassertion is taken at the next posedge.
- Reset mid-transaction: grant drops immediately without waiting for a clock; no ack or q_valid is produced.
- Latency with stable data: req seen at edge E0 -> gnt high after E0. q and q_valid appear after E(SETUP_CYC). ack appears after E(SETUP_CYC+HOLD_CYC), and gnt falls at the same edge.
- With defaults, a transaction is 4 edges including the mandatory IDLE cycle: grant at E0, capture at E2, ack at E3, next grant earliest at E4.
- Each setup violation extends capture by the number of cycles already counted plus one.
- All outputs are registered. Pulses last exactly one cycle.
- Simultaneous abort and data change in SETUP: abort wins and no setup_viol is raised.

## Test plan
- Single requester, defaults: req[0]=1, wdata[0]=8'hA5 stable.
  - gnt=4'b0001 after E0; q=8'hA5, q_valid, q_src=0 after E2; ack after E3; busy low after E3.
- Round robin: req=4'b1111 held, distinct data per requester.
  - Grants are 0,1,2,3,0 in order, one transaction per 4 edges.
  - q_src follows the same sequence.
- Setup violation: req[1], wdata[1] changes 8'h11->8'h22 one cycle after grant.
  - setup_viol pulses once; capture is delayed 1 cycle; q=8'h22.
- Hold violation: wdata[2] changes the cycle after capture of 8'h33.
  - hold_viol pulses; q stays 8'h33; ack still occurs on schedule.
- Abort: req[3] drops during SETUP.
  - gnt falls next edge; no q_valid, no ack; q unchanged; ptr unchanged, so the next grant goes to 3 if it re-requests.
- Async reset mid-HOLD: pull rst_n low between edges.
  - All outputs are 0 immediately.
  - After release, a new req[0] is granted normally.
